// File: rtl/edge_pkg.sv
// Shared definitions for the edge detector bank: per-channel mode encodings
// and the helper that gates rise/fall pulses into a tick.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  function automatic logic tick_sel(input mode_e m, input logic r, input logic f);
    return (r & ((m == MODE_RISE) || (m == MODE_BOTH))) |
           (f & ((m == MODE_FALL) || (m == MODE_BOTH)));
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchronizer, optional debounce qualifier, registered
// rise/fall pulses, mode-gated tick and sticky pend flag.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       stable,
  output logic       rise,
  output logic       fall,
  output logic       tick,
  output logic       pend
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], level};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (DB_CYCLES == 0) begin : g_nodb
    // Without debounce the stable flop is the qualifying stage, so the
    // pulse is produced on the same edge that stable changes.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stable <= 1'b0;
        rise   <= 1'b0;
        fall   <= 1'b0;
      end else begin
        stable <= sync_out;
        rise   <= sync_out & ~stable;
        fall   <= ~sync_out & stable;
      end
    end
  end else begin : g_db
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic [CW-1:0] count;
    logic          stable_prev;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count       <= '0;
        stable      <= 1'b0;
        stable_prev <= 1'b0;
        rise        <= 1'b0;
        fall        <= 1'b0;
      end else begin
        stable_prev <= stable;
        rise        <= stable & ~stable_prev;
        fall        <= ~stable & stable_prev;
        if (sync_out == stable) begin
          count <= '0;
        end else if (count == CW'(DB_CYCLES - 1)) begin
          stable <= sync_out;
          count  <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

  assign tick = tick_sel(mode_e'(mode), rise, fall);

  // Set takes priority over clear so an event coinciding with clr is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= 1'b0;
    else       pend <= tick | (pend & ~clr);
  end

endmodule

// File: rtl/edge_detect_bank.sv
// Bank of NCH independent edge-detect channels sharing one clock and reset.
module edge_detect_bank
  import edge_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   level,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   stable,
  output logic [NCH-1:0]   rise,
  output logic [NCH-1:0]   fall,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .level (level[i]),
      .mode  (mode[2*i +: 2]),
      .clr   (clr[i]),
      .stable(stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .tick  (tick[i]),
      .pend  (pend[i])
    );
  end

endmodule
